// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the RS-485 UART transmit and receive paths.
//   rx_state_t        : receiver FSM states
//   DATA_BITS         : data bits per frame (LSB first)
//   START_LEVEL       : line level of the start bit
//   STOP_LEVEL        : line level of the stop bit
//   DEFAULT_OVERSAMPLE: clk cycles per bit period unless overridden
//   majority3()       : 2-of-3 vote used by the bit sampler
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    localparam int   DATA_BITS          = 8;
    localparam logic START_LEVEL        = 1'b0;
    localparam logic STOP_LEVEL         = 1'b1;
    localparam int   DEFAULT_OVERSAMPLE = 8;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler
// Front end of the UART receiver: synchronises the serial line, detects the
// falling edge that may begin a frame, runs the per-bit oversample counter and
// produces a 3-sample majority vote around the bit centre.
// Ports:
//   clk       in   sample clock (OVERSAMPLE x baud)
//   reset     in   asynchronous, active-low
//   rx        in   raw serial line, asynchronous to clk, idle high
//   run       in   keep the bit counter running next cycle (receiver busy)
//   rxs       out  synchronised line level
//   fall      out  rxs is 0 now and was 1 on the previous clk
//   cnt       out  position within the current bit period, 0..OVERSAMPLE-1
//   bitVal    out  majority of rxs at cnt = MID-1, MID, MID+1
//   bitStrobe out  bitVal is valid (cnt = MID+1)
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
    localparam int CW        = $clog2(OVERSAMPLE)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          rx,
    input  logic          run,
    output logic          rxs,
    output logic          fall,
    output logic [CW-1:0] cnt,
    output logic          bitVal,
    output logic          bitStrobe
);

    localparam int MID = OVERSAMPLE / 2;

    logic          sync1_reg;
    logic          sync2_reg;
    logic          prev_reg;
    logic [CW-1:0] cnt_reg;
    logic          s0_reg;
    logic          s1_reg;

    // The counter sits at 0 while idle, so the falling-edge cycle itself is
    // position 0 of the start bit and the vote lands on the true bit centre.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_reg <= 1'b1;
            sync2_reg <= 1'b1;
            prev_reg  <= 1'b1;
            cnt_reg   <= '0;
            s0_reg    <= 1'b0;
            s1_reg    <= 1'b0;
        end else begin
            sync1_reg <= rx;
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
            if (run) begin
                cnt_reg <= (cnt_reg == CW'(OVERSAMPLE - 1)) ? '0 : cnt_reg + CW'(1);
            end else begin
                cnt_reg <= '0;
            end
            if (cnt_reg == CW'(MID - 1)) begin
                s0_reg <= sync2_reg;
            end
            if (cnt_reg == CW'(MID)) begin
                s1_reg <= sync2_reg;
            end
        end
    end

    assign rxs       = sync2_reg;
    assign fall      = prev_reg & ~sync2_reg;
    assign cnt       = cnt_reg;
    // Third sample is the live rxs, so the vote is complete at cnt = MID+1.
    assign bitVal    = majority3(s0_reg, s1_reg, sync2_reg);
    assign bitStrobe = (cnt_reg == CW'(MID + 1));

endmodule

// File: rtl/uart_rx_frame.sv
// uart_rx_frame
// UART frame receiver (start 0, 8 data bits LSB first, stop 1, no parity)
// with packet byte counting and an idle timeout that resynchronises the
// byte counter.
// Ports:
//   clk        in   sample clock = OVERSAMPLE x baud
//   reset      in   asynchronous, active-low
//   rx         in   serial line from the RS-485 transceiver, idle high
//   data       out  last correctly received byte
//   byteIdx    out  position of data within the packet, 0..BYTES-1
//   valid      out  one-clk strobe: data/byteIdx updated
//   frameErr   out  one-clk strobe: stop bit sampled 0
//   packetDone out  one-clk strobe together with valid of byte BYTES-1
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE   = DEFAULT_OVERSAMPLE,
    parameter int BYTES        = 1,
    parameter int TIMEOUT_BITS = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic [4:0] byteIdx,
    output logic       valid,
    output logic       frameErr,
    output logic       packetDone
);

    localparam int CW    = $clog2(OVERSAMPLE);
    localparam int BW    = $clog2(DATA_BITS);
    localparam int LIMIT = TIMEOUT_BITS * OVERSAMPLE;
    localparam int IW    = $clog2(LIMIT);

    rx_state_t state_reg, state_next;

    logic          rxs;
    logic          fall;
    logic [CW-1:0] cnt;
    logic          bit_val;
    logic          bit_strobe;
    logic          wrap;

    logic          start_go;
    logic          sample_bit;
    logic          bit_inc;
    logic          frame_ok;
    logic          frame_bad;
    logic          run;
    logic          last_byte;
    logic          idle_counting;
    logic          timeout_hit;

    logic [BW-1:0]        bit_reg;
    logic [DATA_BITS-1:0] shift_reg;
    logic [4:0]           byte_cnt_reg;
    logic [IW-1:0]        idle_cnt_reg;
    logic [7:0]           data_reg;
    logic [4:0]           byte_idx_reg;
    logic                 valid_reg;
    logic                 frame_err_reg;
    logic                 packet_done_reg;

    uart_rx_sampler #(
        .OVERSAMPLE (OVERSAMPLE)
    ) u_sampler (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .run       (run),
        .rxs       (rxs),
        .fall      (fall),
        .cnt       (cnt),
        .bitVal    (bit_val),
        .bitStrobe (bit_strobe)
    );

    assign wrap = (cnt == CW'(OVERSAMPLE - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        start_go   = 1'b0;
        sample_bit = 1'b0;
        bit_inc    = 1'b0;
        frame_ok   = 1'b0;
        frame_bad  = 1'b0;
        case (state_reg)
            IDLE: begin
                // fall already implies rxs low; the level test keeps the
                // start condition readable against START_LEVEL.
                if (fall && (rxs == START_LEVEL)) begin
                    start_go   = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                if (bit_strobe && (bit_val != START_LEVEL)) begin
                    state_next = IDLE;
                end else if (wrap) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                sample_bit = bit_strobe;
                if (wrap) begin
                    bit_inc = 1'b1;
                    if (bit_reg == BW'(DATA_BITS - 1)) begin
                        state_next = STOP;
                    end
                end
            end
            STOP: begin
                // Decide at the stop-bit centre and leave at once; the next
                // frame still needs its own falling edge.
                if (bit_strobe) begin
                    frame_ok   = (bit_val == STOP_LEVEL);
                    frame_bad  = (bit_val != STOP_LEVEL);
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign run           = (state_next != IDLE);
    assign last_byte     = (byte_cnt_reg == 5'(BYTES - 1));
    assign idle_counting = (state_reg == IDLE) && !start_go && (byte_cnt_reg != 5'd0);
    assign timeout_hit   = idle_counting && (idle_cnt_reg == IW'(LIMIT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_reg         <= '0;
            shift_reg       <= '0;
            byte_cnt_reg    <= '0;
            idle_cnt_reg    <= '0;
            data_reg        <= '0;
            byte_idx_reg    <= '0;
            valid_reg       <= 1'b0;
            frame_err_reg   <= 1'b0;
            packet_done_reg <= 1'b0;
        end else begin
            valid_reg       <= frame_ok;
            frame_err_reg   <= frame_bad;
            packet_done_reg <= frame_ok && last_byte;

            if (start_go) begin
                bit_reg <= '0;
            end else if (bit_inc) begin
                bit_reg <= bit_reg + BW'(1);
            end

            if (sample_bit) begin
                shift_reg[bit_reg] <= bit_val;
            end

            if (frame_ok) begin
                data_reg     <= shift_reg;
                byte_idx_reg <= byte_cnt_reg;
                byte_cnt_reg <= last_byte ? 5'd0 : byte_cnt_reg + 5'd1;
            end else if (frame_bad || timeout_hit) begin
                byte_cnt_reg <= '0;
            end

            // Idle time only matters part-way through a packet.
            if (start_go || timeout_hit) begin
                idle_cnt_reg <= '0;
            end else if (idle_counting) begin
                idle_cnt_reg <= idle_cnt_reg + IW'(1);
            end else if (state_reg == IDLE) begin
                idle_cnt_reg <= '0;
            end
        end
    end

    assign data       = data_reg;
    assign byteIdx    = byte_idx_reg;
    assign valid      = valid_reg;
    assign frameErr   = frame_err_reg;
    assign packetDone = packet_done_reg;

endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame
// Two receivers (BYTES=1 and BYTES=2) share one serial line. The bench
// predicts every strobe (cycle, kind, data, byteIdx, packetDone) from the
// frame rules: fixed decode latency after the synchronised start edge,
// packet position counting, frame-error clearing and the idle timeout.
module tb_uart_rx_frame;
    import uart_pkg::*;

    localparam int OS    = 8;
    localparam int MID   = OS / 2;
    localparam int TO    = 16;
    localparam int LIMIT = TO * OS;
    localparam int SYNC  = 2;                   // rx -> rxs delay in clk
    localparam int LAT   = 9 * OS + MID + 2;    // first rxs=0 -> strobe

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx    = 1'b1;

    logic [7:0] d1_data,  d2_data;
    logic [4:0] d1_idx,   d2_idx;
    logic       d1_valid, d2_valid;
    logic       d1_ferr,  d2_ferr;
    logic       d1_pd,    d2_pd;

    uart_rx_frame #(.OVERSAMPLE(OS), .BYTES(1), .TIMEOUT_BITS(TO)) u1 (
        .clk        (clk),
        .reset      (rst_n),
        .rx         (rx),
        .data       (d1_data),
        .byteIdx    (d1_idx),
        .valid      (d1_valid),
        .frameErr   (d1_ferr),
        .packetDone (d1_pd)
    );

    uart_rx_frame #(.OVERSAMPLE(OS), .BYTES(2), .TIMEOUT_BITS(TO)) u2 (
        .clk        (clk),
        .reset      (rst_n),
        .rx         (rx),
        .data       (d2_data),
        .byteIdx    (d2_idx),
        .valid      (d2_valid),
        .frameErr   (d2_ferr),
        .packetDone (d2_pd)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        bit         v;
        bit         fe;
        bit         pd;
        logic [7:0] dat;
        logic [4:0] idx;
    } ev_t;

    ev_t q0[$];
    ev_t q1[$];

    int n_pass   = 0;
    int n_checks = 0;

    // reference model state, one slot per receiver
    int bcnt[2];
    int ldat[2];
    int lidx[2];
    int idle_ref[2];
    int nbytes[2];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            bcnt[d]     = 0;
            ldat[d]     = 0;
            lidx[d]     = 0;
            idle_ref[d] = 0;
        end
    endtask

    task automatic apply_timeout(input int d, input int f);
        if (bcnt[d] != 0 && (f - idle_ref[d]) >= LIMIT) bcnt[d] = 0;
    endtask

    // Frame whose first line-low clk is 'start'.
    task automatic model_frame(input logic [7:0] b, input bit ok, input int start);
        ev_t e;
        int  f;
        f = start + SYNC;
        for (int d = 0; d < 2; d++) begin
            apply_timeout(d, f);
            e.cyc = f + LAT;
            e.v   = ok;
            e.fe  = !ok;
            if (ok) begin
                e.pd    = (bcnt[d] == nbytes[d] - 1);
                e.dat   = b;
                e.idx   = 5'(bcnt[d]);
                ldat[d] = int'(b);
                lidx[d] = bcnt[d];
                bcnt[d] = (bcnt[d] + 1) % nbytes[d];
            end else begin
                e.pd    = 1'b0;
                e.dat   = 8'(ldat[d]);
                e.idx   = 5'(lidx[d]);
                bcnt[d] = 0;
            end
            idle_ref[d] = e.cyc;
            if (d == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
    endtask

    // A rejected start returns to idle one clk after the start-bit vote.
    task automatic model_glitch(input int start);
        int f;
        f = start + SYNC;
        for (int d = 0; d < 2; d++) begin
            apply_timeout(d, f);
            idle_ref[d] = f + MID + 2;
        end
    endtask

    task automatic mon(input int d, input logic v, input logic fe, input logic pd,
                       input logic [7:0] dat, input logic [4:0] idx);
        ev_t   e;
        bit    have;
        string p;
        p    = $sformatf("u%0d", d + 1);
        have = (d == 0) ? (q0.size() > 0 && q0[0].cyc == cyc)
                        : (q1.size() > 0 && q1[0].cyc == cyc);
        if (have) begin
            e = (d == 0) ? q0.pop_front() : q1.pop_front();
            check_val({p, "_valid"},      32'(v),   32'(e.v));
            check_val({p, "_frameErr"},   32'(fe),  32'(e.fe));
            check_val({p, "_packetDone"}, 32'(pd),  32'(e.pd));
            check_val({p, "_data"},       32'(dat), 32'(e.dat));
            check_val({p, "_byteIdx"},    32'(idx), 32'(e.idx));
            $display("u%0d cyc %0d: valid=%0d frameErr=%0d packetDone=%0d data=%02h byteIdx=%0d",
                     d + 1, cyc, v, fe, pd, dat, idx);
        end else if (v || fe || pd) begin
            check_val({p, "_spurious_strobe"}, 32'({v, fe, pd}), 32'd0);
        end
    endtask

    always @(negedge clk) begin
        mon(0, d1_valid, d1_ferr, d1_pd, d1_data, d1_idx);
        mon(1, d2_valid, d2_ferr, d2_pd, d2_data, d2_idx);
    end

    // Every drive happens 1 time unit after a rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic lvl);
        rx = lvl;
        repeat (OS) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit ok, input int gap);
        model_frame(b, ok, cyc);
        drive_bit(START_LEVEL);
        for (int i = 0; i < DATA_BITS; i++) drive_bit(b[i]);
        drive_bit(ok ? STOP_LEVEL : ~STOP_LEVEL);
        rx = 1'b1;
        repeat (gap) step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] abort_b;
        logic [7:0] rb;
        bit         ok;
        int         sel;
        int         gap;

        nbytes[0] = 1;
        nbytes[1] = 2;
        model_reset();

        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (3) step();
        check_val("rst_u1_data",       32'(d1_data),  32'd0);
        check_val("rst_u1_byteIdx",    32'(d1_idx),   32'd0);
        check_val("rst_u1_valid",      32'(d1_valid), 32'd0);
        check_val("rst_u1_frameErr",   32'(d1_ferr),  32'd0);
        check_val("rst_u1_packetDone", 32'(d1_pd),    32'd0);
        check_val("rst_u2_data",       32'(d2_data),  32'd0);
        rst_n = 1'b1;
        repeat (4) step();

        // single byte, latency and BYTES=1 packetDone
        send_frame(8'hA5, 1'b1, 20 * OS);

        // back-to-back pair, then one more to see the index wrap
        send_frame(8'h12, 1'b1, 0);
        send_frame(8'h34, 1'b1, 4 * OS);
        send_frame(8'h56, 1'b1, 4 * OS);

        // 2-clk glitch on the idle line, then a real frame
        model_glitch(cyc);
        rx = 1'b0;
        step();
        step();
        rx = 1'b1;
        repeat (4 * OS) step();
        check_val("glitch_u1_state", 32'(u1.state_reg), 32'(IDLE));
        check_val("glitch_u2_state", 32'(u2.state_reg), 32'(IDLE));
        send_frame(8'h5A, 1'b1, 4 * OS);

        // stop bit low: frameErr, data held, byte counter cleared
        send_frame(8'hFF, 1'b0, 4 * OS);
        send_frame(8'h11, 1'b1, 20 * OS);
        // 20 idle bit periods inside the packet: counter resynchronised
        send_frame(8'h22, 1'b1, 4 * OS);

        // reset in the middle of data bit 4
        abort_b = 8'hC3;
        drive_bit(START_LEVEL);
        for (int i = 0; i < 4; i++) drive_bit(abort_b[i]);
        rx = abort_b[4];
        repeat (4) step();
        rst_n = 1'b0;
        rx    = 1'b1;
        model_reset();
        #1;
        check_val("midrst_u2_data",    32'(d2_data), 32'd0);
        check_val("midrst_u2_byteIdx", 32'(d2_idx),  32'd0);
        repeat (3) step();
        rst_n = 1'b1;
        repeat (4) step();
        send_frame(8'h3C, 1'b1, 4 * OS);

        // random traffic
        for (int k = 0; k < 24; k++) begin
            rb  = 8'($urandom_range(0, 255));
            ok  = ($urandom_range(0, 6) != 0);
            sel = $urandom_range(0, 2);
            if (sel == 0)      gap = 0;
            else if (sel == 1) gap = $urandom_range(1, 3 * OS);
            else               gap = $urandom_range(20 * OS, 24 * OS);
            if (!ok && gap < OS) gap = OS;
            send_frame(rb, ok, gap);
        end

        repeat (4 * OS) step();
        check_val("u1_pending_events", 32'(q0.size()), 32'd0);
        check_val("u2_pending_events", 32'(q1.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
